imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of the instruction-memory fetch path: receives a byte-serial program image,
//   packs it into 32-bit big-endian words and writes them into instruction memory at
//   BASE_ADDR + 4*i. Holds the CPU (forces PCWre low via cpu_hold) while loading, so the
//   single-cycle core starts fetching at PC=0 only once the image is complete.
// PARAMETERS
//   BASE_ADDR  32'h0  byte address of first written word (word aligned)
//   MAX_WORDS  256    largest accepted image length in words
// PORTS
//   clk         in   1   single clock; all state changes on posedge clk
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   begin a load; sampled only in IDLE, DONE, ERROR
//   byte_valid  in   1   byte_data holds a valid byte
//   byte_data   in   8   serial image byte
//   byte_ready  out  1   loader can accept a byte this cycle
//   mem_we      out  1   instruction-memory write strobe, one cycle per word
//   mem_addr    out  32  word byte address for write
//   mem_wdata   out  32  packed instruction word
//   cpu_hold    out  1   1 = CPU PC frozen; core ANDs ~cpu_hold into PCWre
//   done        out  1   image fully written (level, held until next start)
//   error       out  1   bad length header (level, held until next start)
//   word_count  out  16  words written so far in current load
// BEHAVIOUR
//   - Reset (async, rst=1): state IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR,
//     mem_wdata=0, cpu_hold=1, done=0, error=0, word_count=0, byte counter=0, length=0.
//     Reset mid-load aborts; partial words never written; CPU stays held.
//   - Byte transfer occurs on a posedge where byte_valid && byte_ready. Nothing else advances.
//   - Frame: 2-byte big-endian length N (words), then 4*N bytes, MSB of each word first.
//   - States / transitions:
//     IDLE:   byte_ready=0; start -> LEN_HI, clear done/error/word_count, cpu_hold=1.
//     LEN_HI: byte_ready=1; transfer -> length[15:8], go LEN_LO.
//     LEN_LO: byte_ready=1; transfer -> length[7:0]; if N==0 or N>MAX_WORDS -> ERROR,
//             else -> DATA, mem_addr=BASE_ADDR.
//     DATA:   byte_ready=1; shift byte into pack register (wdata = {wdata[23:0],byte});
//             2-bit byte counter wraps 3->0; on the 4th transfer -> WRITE.
//     WRITE:  byte_ready=0; mem_we=1 exactly this cycle with stable addr/wdata;
//             next edge: word_count+1, mem_addr+4; if word_count+1==N -> DONE else DATA.
//     DONE:   done=1, cpu_hold=0, byte_ready=0; start -> LEN_HI (reload, cpu_hold=1).
//     ERROR:  error=1, cpu_hold=1, byte_ready=0; start -> LEN_HI.
//   - Latency: 4th byte of word i accepted at edge k -> mem_we high during cycle k..k+1,
//     word written at edge k+1; next byte accepted no earlier than edge k+2.
//   - start ignored in LEN_HI/LEN_LO/DATA/WRITE; byte_valid ignored while byte_ready=0
//     (source must hold byte until accepted).
//   - mem_addr arithmetic modulo 2^32; word_count 16-bit, never exceeds MAX_WORDS.
//   - cpu_hold falls in the same cycle done rises; never 0 while any write pending.
// TESTING
//   1. rst pulse mid-cycle -> all outputs at reset values immediately, cpu_hold=1, no mem_we.
//   2. start, bytes 00 02 20 08 00 05 AC 01 00 04 -> writes 0x20080005@0x0, 0xAC010004@0x4;
//      done=1, cpu_hold=0, word_count=2.
//   3. Same image with byte_valid gaps of 0-3 idle cycles -> identical writes; no byte
//      accepted during WRITE cycles (byte_ready=0).
//   4. Header 00 00, and header 01 01 (257>MAX_WORDS) -> error=1, cpu_hold=1, no mem_we.
//   5. rst asserted after 6 data bytes -> no partial write; then fresh 1-word load writes @0x0.
//   6. start pulsed during DATA -> ignored; after done, second start reloads, cpu_hold=1 again.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial program image loader: packs big-endian bytes into 32-bit words and
// writes them to instruction memory, holding the CPU until the full image is in.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nx;
    logic [15:0] length;
    logic [1:0]  byte_cnt;
    logic [15:0] len_full;
    logic        len_bad;
    logic [15:0] count_inc;
    logic        accept;

    // Length as it will be once the low header byte lands.
    assign len_full  = {length[15:8], byte_data};
    assign len_bad   = (len_full == 16'd0) || ({1'b0, len_full} > MAX_W);
    assign count_inc = word_count + 16'd1;
    assign accept    = byte_valid && byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LEN_HI;
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nx = LEN_LO;
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nx = len_bad ? ERROR : DATA;
            end
            DATA: begin
                byte_ready = 1'b1;
                if (byte_valid && (byte_cnt == 2'd3)) state_nx = WRITE;
            end
            WRITE: begin
                mem_we   = 1'b1;
                state_nx = (count_inc == length) ? DONE : DATA;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = LEN_HI;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_nx = LEN_HI;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            length     <= 16'd0;
            byte_cnt   <= 2'd0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= 32'd0;
            word_count <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        word_count <= 16'd0;
                        byte_cnt   <= 2'd0;
                    end
                end
                LEN_HI: begin
                    if (accept) length[15:8] <= byte_data;
                end
                LEN_LO: begin
                    if (accept) begin
                        length[7:0] <= byte_data;
                        mem_addr    <= BASE_ADDR;
                        byte_cnt    <= 2'd0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        mem_wdata <= {mem_wdata[23:0], byte_data};
                        byte_cnt  <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= count_inc;
                    mem_addr   <= mem_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected memory writes are queued
// from a frame-level model and popped by a monitor whenever mem_we is seen.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [63:0] exp_q[$];

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            chk("hold_during_write", {63'd0, cpu_hold}, 64'd1);
            chk("ready_during_write", {63'd0, byte_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_wdata}, 64'hx);
            end else begin
                chk("write_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, {32'd0, BASE});
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_word_count", {48'd0, word_count}, 64'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            chk("byte_accept_timeout", 64'd0, 64'd1);
        end else begin
            tick();
        end
        byte_valid = 1'b0;
        byte_data  = $urandom_range(0, 255);
    endtask

    task automatic build_image(input int n, input bit fixed);
        img.delete();
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        if (n >= 1 && n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] w;
                w = fixed ? ((i == 0) ? 32'h20080005 : 32'hAC010004) : $urandom;
                for (int j = 3; j >= 0; j--) img.push_back(w[8*j +: 8]);
            end
        end
    endtask

    // Full load: queue expected writes from the frame, drive it, check final status.
    task automatic run_load(input int maxgap, input bit poke_start);
        int  n;
        bit  bad;
        int  t;
        n   = {img[0], img[1]};
        bad = (n == 0) || (n > MAXW);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({BASE + 32'(4 * i),
                                 img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
            end
        end
        pulse_start();
        chk("start_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("start_done_clr", {62'd0, done, error}, 64'd0);
        chk("start_count_clr", {48'd0, word_count}, 64'd0);
        for (int k = 0; k < img.size(); k++) begin
            send_byte(img[k], $urandom_range(0, maxgap));
            if (poke_start && k == 4) pulse_start();
        end
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 30) begin
            tick();
            t++;
        end
        if (bad) begin
            chk("err_flag", {62'd0, error, done}, 64'd2);
            chk("err_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        end else begin
            chk("done_flag", {62'd0, done, error}, 64'd2);
            chk("done_cpu_hold", {63'd0, cpu_hold}, 64'd0);
            chk("done_word_count", {48'd0, word_count}, 64'(n));
        end
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        chk("status_held", {62'd0, done, error}, bad ? 64'd1 : 64'd2);
        exp_q.delete();
    endtask

    initial begin
        #1;
        check_reset();
        #20;
        rst = 1'b0;
        tick();

        // Async reset mid-cycle during a load.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        tick();
        rst = 1'b0;
        tick();

        // Reference image, back-to-back then with gaps.
        build_image(2, 1'b1);
        run_load(0, 1'b0);
        build_image(2, 1'b1);
        run_load(3, 1'b0);

        // Bad headers.
        img.delete(); img.push_back(8'h00); img.push_back(8'h00);
        run_load(2, 1'b0);
        img.delete(); img.push_back(8'h01); img.push_back(8'h01);
        run_load(2, 1'b0);

        // Reset after 6 data bytes: only the first complete word is written.
        build_image(2, 1'b1);
        exp_q.push_back({BASE, 32'h20080005});
        pulse_start();
        for (int k = 0; k < 8; k++) send_byte(img[k], 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        chk("partial_not_written", 64'(exp_q.size()), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        build_image(1, 1'b0);
        run_load(1, 1'b0);

        // start during DATA is ignored; reloading after done holds the CPU again.
        build_image(3, 1'b0);
        run_load(2, 1'b1);
        build_image(2, 1'b0);
        run_load(1, 1'b1);

        // Largest legal image.
        build_image(MAXW, 1'b0);
        run_load(0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            build_image($urandom_range(1, 6), 1'b0);
            run_load(3, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
